// File: rtl/psum_accumulator.sv
// Merges the MAC array's two partial sums per beat and accumulates them over a
// programmable number of beats, emitting a full-precision and a requantized result.
module psum_accumulator #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 8,
    parameter int RES_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [PSUM_W-1:0] psum_0_i,
    input  logic signed [PSUM_W-1:0] psum_1_i,
    input  logic                     psum_valid_i,
    output logic                     psum_ready_o,
    input  logic        [CNT_W-1:0]  num_beats_i,
    input  logic        [4:0]        shift_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic signed [RES_W-1:0]  res_o,
    output logic                     sat_o,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic                     busy_o
);

    // Handshakes: a beat transfers on a rising edge where psum_valid_i & psum_ready_o;
    // a result transfers where res_valid_o & res_ready_i. Producers hold data stable
    // while valid is high and not yet accepted; ready never depends on valid.

    localparam logic signed [ACC_W:0] RES_MAX = {{(ACC_W + 2 - RES_W){1'b0}}, {(RES_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] RES_MIN = {{(ACC_W + 2 - RES_W){1'b1}}, {(RES_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] beat_val;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] final_sum;
    logic        [CNT_W-1:0] cnt_q;
    logic        [CNT_W-1:0] n_q;
    logic        [CNT_W-1:0] n_first;
    logic        [CNT_W-1:0] n_eff;
    logic                    is_first;
    logic                    is_last;
    logic                    beat_accept;
    logic                    res_take;

    logic signed [ACC_W:0]   q_ext;
    logic signed [ACC_W:0]   q_rnd;
    logic signed [ACC_W:0]   q_sum;
    logic signed [ACC_W:0]   q_shr;
    logic signed [RES_W-1:0] res_next;
    logic                    sat_next;

    assign beat_val  = ACC_W'(psum_0_i) + ACC_W'(psum_1_i);
    assign is_first  = (cnt_q == '0);
    assign n_first   = (num_beats_i == '0) ? CNT_W'(1) : num_beats_i;
    assign n_eff     = is_first ? n_first : n_q;
    assign is_last   = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == {1'b0, n_eff});
    assign final_sum = is_first ? beat_val : (acc_q + beat_val);

    assign psum_ready_o = ~rst_i & (~is_last | ~res_valid_o | res_ready_i);
    assign beat_accept  = psum_valid_i & psum_ready_o;
    assign res_take     = res_valid_o & res_ready_i;
    assign busy_o       = (cnt_q != '0);

    // Round half toward +inf, then arithmetic shift, in one extra bit of headroom.
    always_comb begin
        q_ext = (ACC_W + 1)'(final_sum);
        q_rnd = '0;
        if (shift_i != 5'd0) begin
            q_rnd = (ACC_W + 1)'(1) <<< (shift_i - 5'd1);
        end
        q_sum    = q_ext + q_rnd;
        q_shr    = q_sum >>> shift_i;
        res_next = q_shr[RES_W-1:0];
        sat_next = 1'b0;
        if (q_shr > RES_MAX) begin
            res_next = RES_MAX[RES_W-1:0];
            sat_next = 1'b1;
        end else if (q_shr < RES_MIN) begin
            res_next = RES_MIN[RES_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            acc_o       <= '0;
            res_o       <= '0;
            sat_o       <= 1'b0;
            res_valid_o <= 1'b0;
        end else begin
            if (res_take) begin
                res_valid_o <= 1'b0;
            end
            if (beat_accept) begin
                if (is_last) begin
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    acc_o       <= final_sum;
                    res_o       <= res_next;
                    sat_o       <= sat_next;
                    res_valid_o <= 1'b1;
                end else begin
                    acc_q <= final_sum;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_first) begin
                        n_q <= n_eff;
                    end
                end
            end
        end
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream stage of the 8-lane signed MAC array.
- Each accepted beat carries the array's two partial sums; the block merges them and accumulates over a programmable number of beats (K-tiling of a long dot product).
- Once per group it emits the full-precision sum plus a rounded, right-shifted, saturated narrow result under a valid/ready handshake.

Parameters:
- PSUM_W, 20, width of each incoming partial sum (MAC array OUT_SIZE = 4+8+8).
- ACC_W, 32, accumulator and full-precision result width; must be >= PSUM_W+1.
- CNT_W, 8, width of the beats-per-group field.
- RES_W, 8, width of the requantized signed result.

Ports:
- clk_i  in  1  clock; all registers on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- psum_0_i  in  PSUM_W  signed partial sum 0.
- psum_1_i  in  PSUM_W  signed partial sum 1.
- psum_valid_i  in  1  beat valid.
- psum_ready_o  out  1  beat accepted when psum_valid_i & psum_ready_o.
- num_beats_i  in  CNT_W  beats per group; sampled on the first beat of a group; 0 is treated as 1.
- shift_i  in  5  requantization right-shift amount (0..31); sampled on the last beat of a group.
- acc_o  out  ACC_W  signed full-precision group sum.
- res_o  out  RES_W  signed requantized result.
- sat_o  out  1  res_o was clipped.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumed when res_valid_o & res_ready_i.
- busy_o  out  1  a group is partially accumulated (beat count != 0).

Behaviour:
- Reset (async, rst_i=1): acc register, beat counter, latched N, acc_o, res_o, sat_o, res_valid_o, busy_o all 0; psum_ready_o forced 0 while rst_i=1. Reset mid-group discards the partial sum; the next accepted beat starts a new group.
- Beat value: sign-extend psum_0_i and psum_1_i to ACC_W, then add. Accumulation is two's-complement modulo 2^ACC_W; wrap-around is silent, no overflow flag.
- First beat of a group (counter=0):
  - latch N = max(num_beats_i,1);
  - acc register <= beat value;
  - counter <= 1.
- Later beats: acc register <= acc register + beat value; counter <= counter+1.
- Last beat: the beat for which counter+1 == N, including the first beat when N=1. On it:
  - final = acc register + beat (or beat alone if first);
  - result registers load the values below;
  - acc register and counter clear;
  - next cycle res_valid_o=1.
  - Latency: result is valid one cycle after the last beat is accepted.
- Requantization (computed in ACC_W+1 bits):
  - if shift_i=0: r = final;
  - else r = (final + 2^(shift_i-1)) >>> shift_i (round half toward +inf).
  - If r > 2^(RES_W-1)-1: res_o = 2^(RES_W-1)-1, sat_o=1.
  - If r < -2^(RES_W-1): res_o = -2^(RES_W-1), sat_o=1.
  - Otherwise res_o = r[RES_W-1:0], sat_o=0.
  - acc_o = final.
- Output hold:
  - res_valid_o stays 1 and acc_o/res_o/sat_o stay stable until the handshake completes.
  - res_valid_o clears on handshake unless a new last beat loads in the same cycle, in which case it stays 1 with the new values.
- psum_ready_o = ~rst_i & (~is_last | ~res_valid_o | res_ready_i).
  - Non-last beats of the next group are always accepted while a result is pending.
  - Only the last beat stalls on backpressure. There is no combinational path from psum_valid_i to psum_ready_o other than via is_last, which depends on registered state only.
- busy_o = (counter != 0).
- num_beats_i changes mid-group are ignored until the next group.

Test Plan:
- N=1, psum0=100, psum1=-30, shift=0 -> one cycle later res_valid_o=1, acc_o=70, res_o=70, sat_o=0.
- N=4, each beat psum0=1000, psum1=24, shift=4 -> acc_o=4096, r=256 -> res_o=127, sat_o=1.
- N=2, each beat psum0=psum1=-524288, shift=14 -> acc_o=-2097152, res_o=-128, sat_o=0.
- Rounding, N=1, shift=1:
  - psum0=3, psum1=0 -> res_o=2;
  - psum0=-3, psum1=0 -> res_o=-1;
  - psum0=1, psum1=0 -> res_o=1.
- Backpressure: res_ready_i=0 with a result pending; stream N=3 group of 5+5 per beat.
  - Beats 1-2 accepted; beat 3 sees psum_ready_o=0.
  - Old res_o stays stable.
  - Raise res_ready_i -> beat 3 accepted in the same cycle; next cycle acc_o=30 and res_valid_o=1.
- Reset mid-group: N=4, accept 2 beats of 7+0, pulse rst_i asynchronously.
  - All outputs 0 immediately, busy_o=0.
  - Then N=1, psum0=9, psum1=0 -> acc_o=9 (no residue).
